// File: rtl/obstacle_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : obstacle_spawner
//  Purpose  : Frame-rate scheduler for a bank of obstacle slots. It decides
//             when a new obstacle enters, which free slot takes it, and which
//             type it gets, subject to a speed gate and a duplicate limit.
//  Revision : 1.0  initial release
// ============================================================================
module obstacle_spawner #(
   parameter int SLOT_COUNT      = 3,
   parameter int CLEAR_FRAMES    = 180,
   parameter int MAX_DUPLICATION = 2,
   parameter int PTERO_MIN_SPEED = 8704,
   parameter int GAME_WIDTH      = 640
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     update_i,
   input  logic                     game_start_i,
   input  logic                     crash_i,
   input  logic [14:0]              speed_i,
   input  logic [10:0]              rng_data_i,
   input  logic [SLOT_COUNT-1:0]    slot_remove_i,
   input  logic [SLOT_COUNT*11-1:0] slot_x_pos_i,
   input  logic [SLOT_COUNT*10-1:0] slot_width_i,
   input  logic [SLOT_COUNT*11-1:0] slot_gap_i,
   output logic [SLOT_COUNT-1:0]    slot_start_o,
   output logic [SLOT_COUNT*3-1:0]  slot_typ_o,
   output logic [SLOT_COUNT-1:0]    occupied_o,
   output logic [2:0]               last_type_o,
   output logic [1:0]               dup_count_o
);

   // Obstacle type encoding shared with the obstacle instances
   localparam logic [2:0] TYP_NONE  = 3'd0;
   localparam logic [2:0] TYP_SMALL = 3'd1;
   localparam logic [2:0] TYP_LARGE = 3'd2;
   localparam logic [2:0] TYP_PTERO = 3'd3;

   localparam int IW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
   localparam int CW = (CLEAR_FRAMES > 2) ? $clog2(CLEAR_FRAMES) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLEAR   = 2'd1,
      S_ACTIVE  = 2'd2,
      S_CRASHED = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [SLOT_COUNT-1:0]   start_q, start_d;
   logic [SLOT_COUNT*3-1:0] typ_q, typ_d;
   logic [SLOT_COUNT-1:0]   occ_q, occ_d;
   logic [2:0]              last_q, last_d;
   logic [1:0]              dup_q, dup_d;
   logic [IW-1:0]           lslot_q, lslot_d;

   logic [IW-1:0] tgt;
   logic          tgt_found;
   logic [10:0]   l_x;
   logic [9:0]    l_w;
   logic [10:0]   l_g;
   logic          l_free;
   logic [12:0]   right_edge;
   logic          gap_ok;
   logic          spawn;
   logic [2:0]    cand;
   logic [2:0]    typ_fin;
   logic          unused_rng;

   // Only the low two random bits pick the type
   assign unused_rng = ^rng_data_i[10:2];

   // State register and all scheduler state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         start_q <= '0;
         typ_q   <= '0;
         occ_q   <= '0;
         last_q  <= TYP_NONE;
         dup_q   <= 2'd0;
         lslot_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
         typ_q   <= typ_d;
         occ_q   <= occ_d;
         last_q  <= last_d;
         dup_q   <= dup_d;
         lslot_q <= lslot_d;
      end
   end

   // Game-phase FSM; crash overrides every other transition
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (update_i) begin
         if (crash_i) begin
            state_d = S_CRASHED;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (game_start_i) begin
                     state_d = S_CLEAR;
                     cnt_d   = CW'(CLEAR_FRAMES - 1);
                  end
               end
               S_CLEAR: begin
                  if (cnt_q == '0) state_d = S_ACTIVE;
                  else             cnt_d   = cnt_q - CW'(1);
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   // Spawn eligibility: lowest free slot and clearance behind the last spawn
   always_comb begin
      tgt       = '0;
      tgt_found = 1'b0;
      l_x       = '0;
      l_w       = '0;
      l_g       = '0;
      l_free    = 1'b0;
      for (int i = 0; i < SLOT_COUNT; i++) begin
         if (!occ_q[i] && !tgt_found) begin
            tgt       = IW'(i);
            tgt_found = 1'b1;
         end
         if (lslot_q == IW'(i)) begin
            l_x    = slot_x_pos_i[i*11 +: 11];
            l_w    = slot_width_i[i*10 +: 10];
            l_g    = slot_gap_i[i*11 +: 11];
            l_free = !occ_q[i];
         end
      end
      right_edge = {{2{l_x[10]}}, l_x} + {3'b000, l_w} + {2'b00, l_g};
      gap_ok     = $signed(right_edge) < $signed(13'(GAME_WIDTH));
      spawn      = update_i && !crash_i && (state_q == S_ACTIVE) && tgt_found &&
                   ((occ_q == '0) || l_free || gap_ok);
   end

   // Type choice: random pick, then speed gate, then duplicate substitution
   always_comb begin
      case (rng_data_i[1:0])
         2'd1:    cand = TYP_LARGE;
         2'd2:    cand = TYP_PTERO;
         default: cand = TYP_SMALL;
      endcase
      if (cand == TYP_PTERO && speed_i < 15'(PTERO_MIN_SPEED)) cand = TYP_SMALL;
      typ_fin = cand;
      if (cand == last_q && {30'd0, dup_q} >= MAX_DUPLICATION) begin
         typ_fin = (cand == TYP_SMALL) ? TYP_LARGE : TYP_SMALL;
      end
   end

   // Slot bookkeeping: frees, spawns, start pulse and duplicate tracking
   always_comb begin
      start_d = start_q;
      typ_d   = typ_q;
      occ_d   = occ_q;
      last_d  = last_q;
      dup_d   = dup_q;
      lslot_d = lslot_q;
      if (update_i) begin
         start_d = '0;
         if (!crash_i && state_q != S_CRASHED) begin
            // A slot still being started reports a stale remove; ignore it
            for (int i = 0; i < SLOT_COUNT; i++) begin
               if (slot_remove_i[i] && occ_q[i] && !start_q[i]) begin
                  occ_d[i]          = 1'b0;
                  typ_d[i*3 +: 3]   = TYP_NONE;
               end
            end
            if (spawn) begin
               for (int i = 0; i < SLOT_COUNT; i++) begin
                  if (tgt == IW'(i)) begin
                     start_d[i]      = 1'b1;
                     occ_d[i]        = 1'b1;
                     typ_d[i*3 +: 3] = typ_fin;
                  end
               end
               lslot_d = tgt;
               if (typ_fin == last_q) begin
                  dup_d = (dup_q == 2'd3) ? 2'd3 : dup_q + 2'd1;
               end else begin
                  dup_d  = 2'd1;
                  last_d = typ_fin;
               end
            end
         end
      end
   end

   assign slot_start_o = start_q;
   assign slot_typ_o   = typ_q;
   assign occupied_o   = occ_q;
   assign last_type_o  = last_q;
   assign dup_count_o  = dup_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_spawner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obstacle_spawner
//  Purpose  : Self-checking bench for obstacle_spawner (vector table plus
//             scoreboard of expected spawns, and multi-cycle corner cases).
//  Revision : 1.0  initial release
// ============================================================================
module tb_obstacle_spawner;

   localparam int SC = 3;
   localparam int T_NONE  = 0;
   localparam int T_SMALL = 1;
   localparam int T_LARGE = 2;
   localparam int T_PTERO = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            update_i = 1'b0;
   logic            game_start_i = 1'b0;
   logic            crash_i = 1'b0;
   logic [14:0]     speed_i = '0;
   logic [10:0]     rng_data_i = '0;
   logic [SC-1:0]   slot_remove_i = '0;
   logic [SC*11-1:0] slot_x_pos_i = '0;
   logic [SC*10-1:0] slot_width_i = '0;
   logic [SC*11-1:0] slot_gap_i = '0;
   logic [SC-1:0]   slot_start_o;
   logic [SC*3-1:0] slot_typ_o;
   logic [SC-1:0]   occupied_o;
   logic [2:0]      last_type_o;
   logic [1:0]      dup_count_o;

   obstacle_spawner #(
      .SLOT_COUNT(SC), .CLEAR_FRAMES(4), .MAX_DUPLICATION(2),
      .PTERO_MIN_SPEED(8704), .GAME_WIDTH(640)
   ) dut (
      .clk(clk), .rst(rst), .update_i(update_i), .game_start_i(game_start_i),
      .crash_i(crash_i), .speed_i(speed_i), .rng_data_i(rng_data_i),
      .slot_remove_i(slot_remove_i), .slot_x_pos_i(slot_x_pos_i),
      .slot_width_i(slot_width_i), .slot_gap_i(slot_gap_i),
      .slot_start_o(slot_start_o), .slot_typ_o(slot_typ_o),
      .occupied_o(occupied_o), .last_type_o(last_type_o),
      .dup_count_o(dup_count_o)
   );

   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   typedef struct {
      int slot;
      int typ;
      int dup;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [10:0] rng;
      logic [14:0] spd;
      int          typ;
      int          dup;
   } vec_t;
   vec_t vecs[15];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // One update pulse; returns on the falling edge after the update edge
   task automatic tick();
      @(negedge clk);
      update_i = 1'b1;
      @(negedge clk);
      update_i = 1'b0;
   endtask

   task automatic set_slot(input int i, input int x, input int w, input int g);
      slot_x_pos_i[i*11 +: 11] = 11'(x);
      slot_width_i[i*10 +: 10] = 10'(w);
      slot_gap_i[i*11 +: 11]   = 11'(g);
   endtask

   task automatic set_all(input int x, input int w, input int g);
      for (int i = 0; i < SC; i++) set_slot(i, x, w, g);
   endtask

   function automatic int typ_of(input int i);
      return int'(slot_typ_o[i*3 +: 3]);
   endfunction

   task automatic push_exp(input int slot, input int typ, input int dup);
      exp_t e;
      e.slot = slot; e.typ = typ; e.dup = dup;
      sbq.push_back(e);
   endtask

   // Compare the DUT's spawn outputs against the oldest expected spawn
   task automatic pop_check(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         total++;
         $display("FAIL %s: scoreboard empty, got start %0d", tag, slot_start_o);
         return;
      end
      e = sbq.pop_front();
      chk({tag, "_start"}, int'(slot_start_o), 1 << e.slot);
      chk({tag, "_typ"},   typ_of(e.slot), e.typ);
      chk({tag, "_last"},  int'(last_type_o), e.typ);
      chk({tag, "_dup"},   int'(dup_count_o), e.dup);
   endtask

   initial begin
      // rng upper bits carry noise; only bits [1:0] select the type
      vecs[0]  = '{11'h5FA, 15'd8000, T_SMALL, 1};
      vecs[1]  = '{11'h2A6, 15'd9000, T_PTERO, 1};
      vecs[2]  = '{11'h3F4, 15'd9000, T_SMALL, 1};
      vecs[3]  = '{11'h000, 15'd9000, T_SMALL, 2};
      vecs[4]  = '{11'h7FC, 15'd9000, T_LARGE, 1};
      vecs[5]  = '{11'h0AB, 15'd9000, T_SMALL, 1};
      vecs[6]  = '{11'h121, 15'd9000, T_LARGE, 1};
      vecs[7]  = '{11'h001, 15'd9000, T_LARGE, 2};
      vecs[8]  = '{11'h7FD, 15'd9000, T_SMALL, 1};
      vecs[9]  = '{11'h002, 15'd9000, T_PTERO, 1};
      vecs[10] = '{11'h40E, 15'd9000, T_PTERO, 2};
      vecs[11] = '{11'h332, 15'd9000, T_SMALL, 1};
      vecs[12] = '{11'h006, 15'd8703, T_SMALL, 2};
      vecs[13] = '{11'h003, 15'd0,    T_LARGE, 1};
      vecs[14] = '{11'h00A, 15'd8704, T_PTERO, 1};

      // Reset state
      set_all(600, 25, 120);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_start", int'(slot_start_o), 0);
      chk("rst_typ",   int'(slot_typ_o), 0);
      chk("rst_occ",   int'(occupied_o), 0);
      chk("rst_last",  int'(last_type_o), T_NONE);
      chk("rst_dup",   int'(dup_count_o), 0);

      // Start, four clear updates, spawn on the fifth
      game_start_i = 1'b1;
      rng_data_i   = 11'd1;
      tick();
      game_start_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("clear_no_spawn", int'(slot_start_o), 0);
      end
      push_exp(0, T_LARGE, 1);
      tick();
      pop_check("first");
      repeat (3) @(negedge clk);
      chk("start_hold_no_update", int'(slot_start_o), 1);
      tick();
      chk("start_fall", int'(slot_start_o), 0);
      chk("typ_held", typ_of(0), T_LARGE);

      // Clearance behind slot 0: 645 blocks, 639 allows
      set_slot(0, 500, 25, 120);
      tick();
      chk("gap_645_no_spawn", int'(slot_start_o), 0);
      chk("gap_645_occ", int'(occupied_o), 1);
      set_slot(0, 494, 25, 120);
      push_exp(1, T_LARGE, 2);
      tick();
      pop_check("gap_639");

      // Drain both slots; slot 1's remove is stale while its start is pending
      set_all(600, 25, 120);
      slot_remove_i = 3'b011;
      tick();
      chk("drain_stale_rm", int'(occupied_o), 2);
      tick();
      chk("drain_done", int'(occupied_o), 0);
      slot_remove_i = '0;

      // Type selection table
      for (int v = 0; v < 15; v++) begin
         rng_data_i = vecs[v].rng;
         speed_i    = vecs[v].spd;
         push_exp(0, vecs[v].typ, vecs[v].dup);
         tick();
         pop_check($sformatf("vec%0d", v));
         slot_remove_i = 3'b001;
         tick();
         chk("vec_rm_ignored", int'(occupied_o), 1);
         chk("vec_start_fall", int'(slot_start_o), 0);
         tick();
         chk("vec_rm_applied", int'(occupied_o), 0);
         chk("vec_typ_none", typ_of(0), T_NONE);
         slot_remove_i = '0;
      end

      // Fill all slots with clearance always satisfied
      set_all(0, 10, 10);
      rng_data_i = 11'd0;
      speed_i    = 15'd9000;
      push_exp(0, T_SMALL, 1);
      tick();
      pop_check("fill0");
      push_exp(1, T_SMALL, 2);
      tick();
      pop_check("fill1");
      push_exp(2, T_LARGE, 1);
      tick();
      pop_check("fill2");
      tick();
      chk("full_no_spawn", int'(slot_start_o), 0);
      chk("full_occ", int'(occupied_o), 7);

      // Freed slot is reusable only from the next update
      slot_remove_i = 3'b100;
      tick();
      chk("free2_occ", int'(occupied_o), 3);
      chk("free2_no_spawn", int'(slot_start_o), 0);
      chk("free2_typ", typ_of(2), T_NONE);
      slot_remove_i = '0;
      push_exp(2, T_SMALL, 1);
      tick();
      pop_check("reuse2");

      // Crash while slot 1's start is pending
      slot_remove_i = 3'b010;
      tick();
      chk("free1_occ", int'(occupied_o), 5);
      slot_remove_i = '0;
      push_exp(1, T_SMALL, 2);
      tick();
      pop_check("pend1");
      crash_i = 1'b1;
      tick();
      crash_i = 1'b0;
      chk("crash_start", int'(slot_start_o), 0);
      chk("crash_occ", int'(occupied_o), 7);
      chk("crash_typ1", typ_of(1), T_SMALL);
      chk("crash_dup", int'(dup_count_o), 2);
      slot_remove_i = 3'b001;
      tick();
      chk("crashed_no_free", int'(occupied_o), 7);
      chk("crashed_typ0", typ_of(0), T_SMALL);
      slot_remove_i = '0;
      game_start_i  = 1'b1;
      repeat (6) tick();
      game_start_i  = 1'b0;
      chk("crashed_no_spawn", int'(slot_start_o), 0);

      // Mid-operation reset
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_start", int'(slot_start_o), 0);
      chk("rst2_typ",   int'(slot_typ_o), 0);
      chk("rst2_occ",   int'(occupied_o), 0);
      chk("rst2_last",  int'(last_type_o), T_NONE);
      chk("rst2_dup",   int'(dup_count_o), 0);

      if (sbq.size() != 0) begin
         total++;
         $display("FAIL sb_leftover: got %0d entries expected 0", sbq.size());
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
